// File: rtl/fpu_writeback.sv
// Result-side tracker for the vector FPU: tags ops through the fixed pipe,
// queues results with lane masks and keeps a per-register busy scoreboard.
module fpu_writeback #(
    parameter int SIG_WIDTH  = 23,
    parameter int EXP_WIDTH  = 8,
    parameter int LEN        = 9,
    parameter int ADDR_WIDTH = 5,
    parameter int LATENCY    = 3,
    parameter int FIFO_DEPTH = 5
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         issue_valid,
    output logic                                         issue_ready,
    input  logic [ADDR_WIDTH-1:0]                        issue_vd,
    input  logic [7:0]                                   issue_opcode,
    input  logic [3:0]                                   issue_index,
    input  logic [LEN-1:0]                               issue_pred,
    input  logic [LEN*(SIG_WIDTH+EXP_WIDTH+1)-1:0]       fpu_data_out,
    output logic                                         wb_valid,
    input  logic                                         wb_ready,
    output logic [ADDR_WIDTH-1:0]                        wb_addr,
    output logic [LEN*(SIG_WIDTH+EXP_WIDTH+1)-1:0]       wb_data,
    output logic [LEN-1:0]                               wb_mask,
    output logic [(1<<ADDR_WIDTH)-1:0]                   busy
);

    localparam int W     = SIG_WIDTH + EXP_WIDTH + 1;
    localparam int DW    = LEN * W;
    localparam int NREGS = 1 << ADDR_WIDTH;
    localparam int CRW   = $clog2(FIFO_DEPTH + 1);
    localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [CRW-1:0]        credits;
    logic [CRW-1:0]        count;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic [NREGS-1:0]      busy_q;
    logic [NREGS-1:0]      busy_next;

    logic [LATENCY-1:0]    tag_v;
    logic [ADDR_WIDTH-1:0] tag_vd   [LATENCY];
    logic [LEN-1:0]        tag_mask [LATENCY];

    logic [ADDR_WIDTH-1:0] q_vd   [FIFO_DEPTH];
    logic [LEN-1:0]        q_mask [FIFO_DEPTH];
    logic [DW-1:0]         q_data [FIFO_DEPTH];

    logic                  accept;
    logic                  push;
    logic                  pop;
    logic [LEN-1:0]        onehot;
    logic [LEN-1:0]        issue_mask;
    logic                  unused_opcode;

    assign unused_opcode = ^{issue_opcode[7], issue_opcode[4:0]};

    assign issue_ready = (credits != '0) & ~busy_q[issue_vd];
    assign accept      = issue_valid & issue_ready;
    assign push        = tag_v[LATENCY-1];
    assign wb_valid    = (count != '0);
    assign pop         = wb_valid & wb_ready;

    assign wb_addr = q_vd[rd_ptr];
    assign wb_data = q_data[rd_ptr];
    assign wb_mask = wb_valid ? q_mask[rd_ptr] : '0;
    assign busy    = busy_q;

    // Scalar ops write one lane; an out-of-range index writes none.
    always_comb begin
        onehot = '0;
        for (int i = 0; i < LEN; i++) begin
            if (32'(issue_index) == i) onehot[i] = 1'b1;
        end
        issue_mask = issue_pred;
        if (issue_opcode[6:5] == 2'b10) issue_mask = issue_pred & onehot;
    end

    always_comb begin
        busy_next = busy_q;
        if (pop)    busy_next[wb_addr]  = 1'b0;
        if (accept) busy_next[issue_vd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_v   <= '0;
            credits <= CRW'(FIFO_DEPTH);
            count   <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            busy_q  <= '0;
        end else begin
            tag_v[0] <= accept;
            for (int i = 1; i < LATENCY; i++) begin
                tag_v[i] <= tag_v[i-1];
            end
            if (accept && !pop) begin
                credits <= credits - CRW'(1);
            end else if (!accept && pop) begin
                credits <= credits + CRW'(1);
            end
            if (push && !pop) begin
                count <= count + CRW'(1);
            end else if (!push && pop) begin
                count <= count - CRW'(1);
            end
            if (push) begin
                wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end
            busy_q <= busy_next;
        end
    end

    // Payload storage needs no reset; validity lives in tag_v and count.
    always_ff @(posedge clk) begin
        tag_vd[0]   <= issue_vd;
        tag_mask[0] <= issue_mask;
        for (int i = 1; i < LATENCY; i++) begin
            tag_vd[i]   <= tag_vd[i-1];
            tag_mask[i] <= tag_mask[i-1];
        end
        if (push) begin
            q_vd[wr_ptr]   <= tag_vd[LATENCY-1];
            q_mask[wr_ptr] <= tag_mask[LATENCY-1];
            q_data[wr_ptr] <= fpu_data_out;
        end
    end

endmodule

// File: tb/tb_fpu_writeback.sv
// Directed bench for fpu_writeback: hand-computed masks, addresses, latencies
// and a queue of expected results checked at every writeback handshake.
module tb_fpu_writeback;

    localparam int LEN = 9;
    localparam int W   = 32;
    localparam int DW  = LEN * W;
    localparam int AW  = 5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            issue_valid = 1'b0;
    logic            issue_ready;
    logic [AW-1:0]   issue_vd = '0;
    logic [7:0]      issue_opcode = '0;
    logic [3:0]      issue_index = '0;
    logic [LEN-1:0]  issue_pred = '0;
    logic [DW-1:0]   fpu_data_out;
    logic            wb_valid;
    logic            wb_ready = 1'b0;
    logic [AW-1:0]   wb_addr;
    logic [DW-1:0]   wb_data;
    logic [LEN-1:0]  wb_mask;
    logic [31:0]     busy;

    fpu_writeback dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
        .issue_vd     (issue_vd),
        .issue_opcode (issue_opcode),
        .issue_index  (issue_index),
        .issue_pred   (issue_pred),
        .fpu_data_out (fpu_data_out),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .wb_mask      (wb_mask),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0]  vd;
        logic [LEN-1:0] mask;
        logic [DW-1:0]  data;
    } exp_t;

    int             cyc = 0;
    int             n_cmp = 0;
    int             n_err = 0;
    int             wb_cnt = 0;
    int             wb_cyc_q[$];
    exp_t           exp_q[$];
    exp_t           e;
    logic [LEN-1:0] drv_mask = '0;
    logic           hold_prev = 1'b0;
    logic [AW-1:0]  p_addr;
    logic [LEN-1:0] p_mask;
    logic [DW-1:0]  p_data;

    function automatic logic [DW-1:0] dat(int c);
        logic [DW-1:0] d;
        for (int i = 0; i < LEN; i++) begin
            d[i*W +: W] = 32'(c * 16 + i) ^ 32'hA5C3_0000;
        end
        return d;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;
    assign fpu_data_out = dat(cyc);

    task automatic check(string tag, logic [DW-1:0] got, logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Writeback monitor: order, payload and stability under backpressure.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            hold_prev = 1'b0;
        end else begin
            if (hold_prev && wb_valid) begin
                check("hold_addr", DW'(wb_addr), DW'(p_addr));
                check("hold_mask", DW'(wb_mask), DW'(p_mask));
                check("hold_data", wb_data, p_data);
            end
            if (wb_valid && wb_ready) begin
                wb_cnt++;
                wb_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("wb_spurious", DW'(1), DW'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("wb_addr", DW'(wb_addr), DW'(e.vd));
                    check("wb_mask", DW'(wb_mask), DW'(e.mask));
                    check("wb_data", wb_data, e.data);
                end
            end
            if (issue_valid && issue_ready) begin
                e.vd   = issue_vd;
                e.mask = drv_mask;
                e.data = dat(cyc + 3);
                exp_q.push_back(e);
            end
            hold_prev = wb_valid & ~wb_ready;
            p_addr = wb_addr;
            p_mask = wb_mask;
            p_data = wb_data;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_issue(input logic v, input logic [AW-1:0] vd,
                             input logic [7:0] opc, input logic [3:0] idx,
                             input logic [LEN-1:0] pred,
                             input logic [LEN-1:0] m);
        issue_valid  = v;
        issue_vd     = vd;
        issue_opcode = opc;
        issue_index  = idx;
        issue_pred   = pred;
        drv_mask     = m;
    endtask

    task automatic drain(input int budget);
        wb_ready    = 1'b1;
        issue_valid = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 && !wb_valid) return;
            tick;
        end
        check("drain_timeout", DW'(exp_q.size()), DW'(0));
    endtask

    task automatic hold_issue(input int base, input int ncyc, output int acc);
        acc = 0;
        for (int i = 0; i < ncyc; i++) begin
            set_issue(1'b1, AW'(base + acc), 8'h20, 4'd0, 9'h1FF, 9'h1FF);
            @(negedge clk);
            if (issue_ready) acc++;
            tick;
        end
        issue_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t0;
        int ta;
        int w0;
        int acc;
        logic [7:0] opcs [3];
        opcs[0] = 8'h00;
        opcs[1] = 8'h20;
        opcs[2] = 8'h60;

        // Reset state
        set_issue(1'b1, 5'd0, 8'h20, 4'd0, 9'h1FF, 9'h1FF);
        tick;
        tick;
        @(negedge clk);
        check("rst_wb_valid", DW'(wb_valid), DW'(0));
        check("rst_wb_mask", DW'(wb_mask), DW'(0));
        check("rst_busy", DW'(busy), DW'(0));
        check("rst_issue_ready", DW'(issue_ready), DW'(1));
        tick;
        issue_valid = 1'b0;
        rst_n = 1'b1;
        tick;

        // Single vector op, vd=3
        wb_ready = 1'b1;
        set_issue(1'b1, 5'd3, 8'h20, 4'd0, 9'h1FF, 9'h1FF);
        @(negedge clk);
        t0 = cyc;
        check("single_ready", DW'(issue_ready), DW'(1));
        tick;
        issue_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check("single_busy3", DW'(busy[3]), DW'(k <= 4));
            if (k == 4) begin
                check("single_wb_valid", DW'(wb_valid), DW'(1));
                check("single_wb_addr", DW'(wb_addr), DW'(3));
                check("single_wb_mask", DW'(wb_mask), DW'(9'h1FF));
                check("single_wb_data", wb_data, dat(t0 + 3));
            end else begin
                check("single_wb_idle", DW'(wb_valid), DW'(0));
            end
            tick;
        end

        // Scalar masks: index 4 -> lane 4 only, index 12 -> no lanes
        w0 = wb_cnt;
        set_issue(1'b1, 5'd4, 8'h40, 4'd4, 9'h1FF, 9'h010);
        tick;
        set_issue(1'b1, 5'd5, 8'h40, 4'd12, 9'h1FF, 9'h000);
        tick;
        drain(30);
        check("scalar_retired", DW'(wb_cnt - w0), DW'(2));
        check("scalar_busy", DW'(busy), DW'(0));

        // Back-to-back: 10 ops, no bubbles, writebacks from cycle T+4
        wb_cyc_q.delete();
        w0 = wb_cnt;
        t0 = 0;
        for (int k = 0; k < 10; k++) begin
            set_issue(1'b1, AW'(k), opcs[k % 3], 4'd0,
                      9'(k * 37 + 5), 9'(k * 37 + 5));
            @(negedge clk);
            if (k == 0) t0 = cyc;
            check("b2b_ready", DW'(issue_ready), DW'(1));
            tick;
        end
        drain(40);
        check("b2b_count", DW'(wb_cnt - w0), DW'(10));
        for (int i = 0; i < wb_cyc_q.size(); i++) begin
            check("b2b_wb_cycle", DW'(wb_cyc_q[i]), DW'(t0 + 4 + i));
        end

        // Backpressure: exactly FIFO_DEPTH accepts, then stall
        wb_ready = 1'b0;
        w0 = wb_cnt;
        hold_issue(10, 8, acc);
        check("bp_accepts", DW'(acc), DW'(5));
        set_issue(1'b1, 5'd20, 8'h20, 4'd0, 9'h1FF, 9'h1FF);
        @(negedge clk);
        check("bp_blocked", DW'(issue_ready), DW'(0));
        tick;
        drain(40);
        check("bp_drained", DW'(wb_cnt - w0), DW'(5));
        wb_ready = 1'b0;
        hold_issue(10, 7, acc);
        check("bp_credits", DW'(acc), DW'(5));
        drain(40);

        // WAW hazard on vd=7
        wb_ready = 1'b1;
        set_issue(1'b1, 5'd7, 8'h20, 4'd0, 9'h0F0, 9'h0F0);
        @(negedge clk);
        t0 = cyc;
        tick;
        set_issue(1'b1, 5'd7, 8'h60, 4'd0, 9'h00F, 9'h00F);
        ta = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (issue_ready) begin
                ta = cyc;
                break;
            end
            tick;
        end
        check("haz_accept_cycle", DW'(ta), DW'(t0 + 5));
        tick;
        drain(30);

        // Reset with 2 queued and 2 in flight
        wb_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_issue(1'b1, AW'(20 + k), 8'h20, 4'd0, 9'h1FF, 9'h1FF);
            tick;
        end
        issue_valid = 1'b0;
        tick;
        rst_n = 1'b0;
        @(negedge clk);
        check("rstm_queued", DW'(wb_valid), DW'(1));
        tick;
        @(negedge clk);
        check("rstm_wb_valid", DW'(wb_valid), DW'(0));
        check("rstm_busy", DW'(busy), DW'(0));
        tick;
        rst_n = 1'b1;
        w0 = wb_cnt;
        hold_issue(24, 7, acc);
        check("rstm_accepts", DW'(acc), DW'(5));
        drain(40);
        check("rstm_retired", DW'(wb_cnt - w0), DW'(5));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fpu_writeback.md
# fpu_writeback

Result-side companion of the vector FPU datapath. Tracks every operation issued to the FPU through its fixed pipeline latency, captures the `data_out` vector when it emerges, and builds the per-lane write mask from predicate, opcode class and index. Queues results and writes them back to the vector register file over a valid/ready port. Keeps a per-register busy scoreboard that issue logic uses for hazard checks.

## Interface

**Parameters**
- `SIG_WIDTH`, 23: FP significand width.
- `EXP_WIDTH`, 8: FP exponent width. The element width W is SIG_WIDTH+EXP_WIDTH+1.
- `LEN`, 9: lanes per vector.
- `ADDR_WIDTH`, 5: register address width. NREGS is 2^ADDR_WIDTH.
- `LATENCY`, 3: FPU issue-to-result cycles. Must be ≥1.
- `FIFO_DEPTH`, 5: result queue entries. Must be ≥1; full throughput needs ≥ LATENCY+2.

**Ports**
- `clk`, input, 1: clock.
- `rst_n`, input, 1: synchronous active-low reset.
- `issue_valid`, input, 1: an op is presented to the FPU this cycle.
- `issue_ready`, output, 1: the op is accepted. The handshake is `issue_valid & issue_ready`.
- `issue_vd`, input, ADDR_WIDTH: destination register.
- `issue_opcode`, input, 8: FPU opcode. Bits [6:5] select the result class.
- `issue_index`, input, 4: scalar lane index.
- `issue_pred`, input, LEN: lane predicate.
- `fpu_data_out`, input, LEN×W: FPU result vector.
- `wb_valid`, output, 1: a writeback request is pending.
- `wb_ready`, input, 1: the register file accepts the request.
- `wb_addr`, output, ADDR_WIDTH: destination register.
- `wb_data`, output, LEN×W: result vector.
- `wb_mask`, output, LEN: per-lane write enable.
- `busy`, output, NREGS: the register has a pending write.

## Operation

**Issue acceptance**
- `issue_ready = (credits != 0) & ~busy[issue_vd]`.
- This gating prevents write-after-write hazards and guarantees the FIFO never overflows.
- On an accepted issue:
  - push {vd, mask} into stage 0 of a LATENCY-deep tag shift register, with valid=1;
  - decrement `credits`;
  - set `busy[issue_vd]`.

**Mask generation at issue**
- `opcode[6:5]` = 00 (dot-product), 01 (vector), 11 (skew): mask = `issue_pred`.
- `opcode[6:5]` = 10 (scalar): mask = `issue_pred` & one-hot(`issue_index`).
- Scalar with `issue_index` ≥ LEN: mask = 0. The entry still flows through and retires normally.

**Capture**
- When the last tag stage is valid, push {vd, mask, `fpu_data_out`} into the FIFO in the same cycle.
- Space is guaranteed by the credit scheme.

**Writeback**
- `wb_valid` is high when the FIFO is not empty. `wb_addr`, `wb_data` and `wb_mask` come from the FIFO head.
- On `wb_valid & wb_ready`:
  - pop the FIFO;
  - increment `credits`;
  - clear `busy[wb_addr]`.
- Outputs must hold stable while `wb_valid & ~wb_ready`.

**Credits**
- Counter width is clog2(FIFO_DEPTH+1). Reset value is FIFO_DEPTH.
- Invariant: credits + in-flight + FIFO occupancy = FIFO_DEPTH.
- Simultaneous accept and pop: credits unchanged.
- Set and clear of `busy` in the same cycle always target different addresses, because issue is gated by busy.

**FIFO**
- Circular buffer with read/write pointers wrapping at FIFO_DEPTH.
- Simultaneous push and pop when full or empty is legal.
- Push into an empty FIFO becomes visible the next cycle (no bypass).

**Reset** (synchronous, at any time, including mid-operation)
- All tag valids = 0; FIFO empty; `credits` = FIFO_DEPTH; `busy` = 0; `wb_valid` = 0; `wb_mask` = 0.
- In-flight ops are dropped.
- After reset, `issue_ready` = 1 if `issue_valid` is presented.

## Timing

- Issue accepted at cycle T: the FPU result is sampled from `fpu_data_out` at the rising edge that ends cycle T+LATENCY.
- Earliest `wb_valid` is cycle T+LATENCY+1, which is the issue-to-writeback latency.
- Throughput is one result per cycle with `wb_ready` held high and FIFO_DEPTH ≥ LATENCY+2.
- `busy[vd]` rises the cycle after accept and falls the cycle after the writeback handshake.
- `issue_ready` is combinational from `credits`, `busy` and `issue_vd`. All other outputs are registered.

## Test plan

- **Single op:** vector op vd=3, pred=9'h1FF, at T=0, `wb_ready`=1.
  - Requires `wb_valid` at T=4 with `wb_addr`=3, `wb_mask`=1FF and `wb_data` equal to `fpu_data_out` sampled at T=3.
  - Requires `busy[3]` high for T=1..4 and low at T=5.
- **Scalar mask:** opcode[6:5]=10, index=4, pred=1FF → `wb_mask`=9'h010. With index=12 → `wb_mask`=0 and the entry still retires.
- **Back-to-back:** 10 issues to vd=0..9 on consecutive cycles, `wb_ready`=1 → no `issue_ready` bubbles; writebacks in order on consecutive cycles starting at cycle 4.
- **Backpressure:** `wb_ready`=0 with `issue_valid` held.
  - Exactly 5 accepts, then `issue_ready`=0.
  - Raising `wb_ready` drains all 5 in order with stable data; credits return to 5.
- **Hazard:** issue vd=7, then vd=7 again next cycle → second held (`issue_ready`=0) until the cycle after the first writeback handshake.
- **Reset mid-flight:** assert `rst_n`=0 with 2 in-flight ops and 2 queued → next cycle `wb_valid`=0, `busy`=0, and 5 issues are accepted after release.
